fft_band_peak_picker: RTL and testbench
=======================================

Name: fft_band_peak_picker

Overview:
Post-FFT magnitude sweeper for the fingerprinting path. After an FFT frame completes, it walks the FFT magnitude read-out index over the non-mirrored half-spectrum, one bin per magnitude_ready strobe. It splits those bins into NUM_BANDS equal bands and emits one peak record (bin, magnitude, above-threshold flag) per band over a valid/ready stream. It generalises the fixed 1024-point, single-stream magnitude dump to parametrised length, width and band count, and adds peak selection, thresholding and backpressure.

Parameters:
FFT_LENGTH, 1024, FFT points; power of 2, at least 16.
MAG_WIDTH, 16, magnitude width (unsigned).
NUM_BANDS, 8, band count; power of 2, divides FFT_LENGTH/2.
SKIP_DC, 1, if 1, bin 0 is never a peak candidate.

Ports:
clk  in  1  single clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high; clears all state.
start_i  in  1  frame-ready pulse from the FFT (done_FFT); honoured only in IDLE.
threshold_i  in  MAG_WIDTH  peak threshold; sampled on an accepted start_i.
index_o  out  log2(FFT_LENGTH)  bin address driven to the FFT magnitude read-out.
magnitude_i  in  MAG_WIDTH  magnitude for index_o.
magnitude_ready_i  in  1  magnitude_i is valid for the current index_o.
peak_valid_o  out  1  peak record valid.
peak_ready_i  in  1  consumer accepts the record.
peak_band_o  out  log2(NUM_BANDS)  band number, 0 = lowest frequencies.
peak_bin_o  out  log2(FFT_LENGTH)  bin of the band maximum.
peak_mag_o  out  MAG_WIDTH  magnitude of the band maximum.
peak_found_o  out  1  peak_mag_o > sampled threshold (strictly greater).
busy_o  out  1  high in any state except IDLE.
frame_done_o  out  1  one-cycle pulse after the last band's record is accepted.

Behaviour:
- BPB = FFT_LENGTH/2/NUM_BANDS. Band b covers bins b*BPB to b*BPB+BPB-1. Bins FFT_LENGTH/2 and above are never addressed.
- Reset values: all outputs 0. State = IDLE. The threshold register and the best-magnitude/best-bin registers are 0.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - index_o = 0.
  - start_i=1 -> SCAN. Capture threshold_i. Clear best_mag=0 and best_bin = first bin of the band.
- SCAN:
  - Each cycle with magnitude_ready_i=1 accepts magnitude_i as the value of bin index_o.
  - Candidate rule: if magnitude_i > best_mag (strict), update best_mag and best_bin. On a tie the lower bin is kept.
  - With SKIP_DC=1, bin 0 is accepted but never updates best.
  - Accepting a bin that is not the last of its band: index_o increments on the next edge.
  - Accepting the last bin of the band: -> EMIT. peak_* registers load the final best (including the bin accepted this cycle). peak_valid_o goes high the next cycle, one cycle of latency. index_o holds.
- EMIT:
  - peak_valid_o stays high and the peak_* outputs stay stable until peak_valid_o & peak_ready_i.
  - On that handshake, not the last band: peak_valid_o=0, index_o+1, clear best, peak_band_o+1 -> SCAN.
  - On that handshake, last band: -> DONE.
  - magnitude_ready_i is ignored in EMIT.
- DONE:
  - frame_done_o=1 for exactly this one cycle. index_o returns to 0 and peak_band_o to 0 -> IDLE.
- magnitude_ready_i is ignored in IDLE and DONE. start_i is ignored outside IDLE: no restart and no state change.
- Back-to-back magnitude_ready_i (every cycle) is legal. A full scan then takes FFT_LENGTH/2 accept cycles plus one EMIT cycle per band, when peak_ready_i is held at 1.
- peak_ready_i held low stalls indefinitely. No record is dropped and nothing is overwritten.
- Reset asserted mid-scan or mid-EMIT: immediate return to IDLE with reset values. A following start_i begins a fresh frame from band 0.

Test Plan:
(Defaults, so BPB=64.)
1. Ramp: magnitude = bin number, ready every cycle, peak_ready_i=1, threshold 0 -> 8 records. Band b gives bin 64b+63, mag 64b+63, found=1. frame_done_o pulses once, 520 cycles after start.
2. Spike and ties: all magnitudes 5, bin 130 = 900, bins 200 and 210 both = 300 -> band 2 gives bin 130/900. Band 3 gives bin 200/300 (lower bin wins). Band 0 gives bin 1/5, never bin 0.
3. Threshold: threshold_i=300, same data as scenario 2 -> band 3 found=0 (equal, not greater), band 2 found=1. Changing threshold_i mid-frame has no effect.
4. Backpressure: peak_ready_i low for 10 cycles in band 0 EMIT, with magnitude_ready_i still pulsing -> record held stable, index_o frozen at 63, no bins consumed, then the scan resumes at 64.
5. Sparse ready and a busy start: magnitude_ready_i every 3rd cycle; start_i pulsed during SCAN -> results identical to scenario 1, busy_o stays high, no restart.
6. Reset at bin 100: all outputs 0, state IDLE. A new start_i gives a complete 8-record frame starting at band 0.

Source files
------------

// File: rtl/fft_band_peak_picker.sv
// ---------------------------------------------------------------------------
// fft_band_peak_picker
//
// Sweeps the FFT magnitude read-out over the non-mirrored half-spectrum
// (bins 0 .. FFT_LENGTH/2-1), one bin per magnitude_ready_i strobe. The
// half-spectrum is split into NUM_BANDS equal bands. For each band, one peak
// record (band, bin, magnitude, above-threshold flag) is offered on a
// valid/ready stream.
//
// Handshake: a record transfers on a rising edge where
// peak_valid_o & peak_ready_i. While peak_valid_o is high, all peak_* outputs
// hold steady. peak_valid_o never drops without a transfer. peak_ready_i may
// stay low indefinitely, which freezes the sweep.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high; returns to IDLE
//   start_i             frame-ready pulse; accepted only in IDLE
//   threshold_i         peak threshold, captured on an accepted start_i
//   index_o             bin address to the FFT magnitude read-out
//   magnitude_i         magnitude of bin index_o
//   magnitude_ready_i   magnitude_i is valid for index_o this cycle
//   peak_valid_o        peak record valid
//   peak_ready_i        consumer accepts the record
//   peak_band_o         band number of the record (0 = lowest frequencies)
//   peak_bin_o          bin holding the band maximum
//   peak_mag_o          band maximum magnitude
//   peak_found_o        peak_mag_o > captured threshold
//   busy_o              high in every state except IDLE
//   frame_done_o        one-cycle pulse after the last record is accepted
// ---------------------------------------------------------------------------
module fft_band_peak_picker #(
    parameter int FFT_LENGTH = 1024,
    parameter int MAG_WIDTH  = 16,
    parameter int NUM_BANDS  = 8,
    parameter int SKIP_DC    = 1,
    localparam int IW = $clog2(FFT_LENGTH),
    localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [MAG_WIDTH-1:0] threshold_i,
    output logic [IW-1:0]        index_o,
    input  logic [MAG_WIDTH-1:0] magnitude_i,
    input  logic                 magnitude_ready_i,
    output logic                 peak_valid_o,
    input  logic                 peak_ready_i,
    output logic [BW-1:0]        peak_band_o,
    output logic [IW-1:0]        peak_bin_o,
    output logic [MAG_WIDTH-1:0] peak_mag_o,
    output logic                 peak_found_o,
    output logic                 busy_o,
    output logic                 frame_done_o
);

    localparam int BPB = FFT_LENGTH / 2 / NUM_BANDS;

    // BPB is a power of two, so the low index bits give the position in the band.
    localparam logic [IW-1:0] BPB_MASK  = IW'(BPB - 1);
    localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          index_q;
    logic [MAG_WIDTH-1:0]   thresh_q;
    logic [MAG_WIDTH-1:0]   best_mag_q;
    logic [IW-1:0]          best_bin_q;
    logic                   peak_valid_q;
    logic [BW-1:0]          peak_band_q;
    logic [IW-1:0]          peak_bin_q;
    logic [MAG_WIDTH-1:0]   peak_mag_q;
    logic                   peak_found_q;
    logic                   frame_done_q;

    // Running best including the bin presented this cycle.
    logic [MAG_WIDTH-1:0]   best_mag_d;
    logic [IW-1:0]          best_bin_d;
    logic                   take_bin;
    logic                   last_in_band;

    always_comb begin
        // Strict compare keeps the lower bin on ties. Bin 0 is observed but
        // never promoted when DC is excluded.
        take_bin = (magnitude_i > best_mag_q) &&
                   !((SKIP_DC != 0) && (index_q == '0));
        best_mag_d = best_mag_q;
        best_bin_d = best_bin_q;
        if (take_bin) begin
            best_mag_d = magnitude_i;
            best_bin_d = index_q;
        end
        last_in_band = ((index_q & BPB_MASK) == BPB_MASK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            thresh_q     <= '0;
            best_mag_q   <= '0;
            best_bin_q   <= '0;
            peak_valid_q <= 1'b0;
            peak_band_q  <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_found_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        thresh_q    <= threshold_i;
                        best_mag_q  <= '0;
                        best_bin_q  <= '0;
                        index_q     <= '0;
                        peak_band_q <= '0;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (magnitude_ready_i) begin
                        best_mag_q <= best_mag_d;
                        best_bin_q <= best_bin_d;
                        if (last_in_band) begin
                            // Index holds on the last bin until the record drains.
                            peak_mag_q   <= best_mag_d;
                            peak_bin_q   <= best_bin_d;
                            peak_found_q <= (best_mag_d > thresh_q);
                            peak_valid_q <= 1'b1;
                            state_q      <= ST_EMIT;
                        end else begin
                            index_q <= index_q + IW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (peak_ready_i) begin
                        peak_valid_q <= 1'b0;
                        if (peak_band_q == LAST_BAND) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            index_q     <= index_q + IW'(1);
                            best_mag_q  <= '0;
                            best_bin_q  <= index_q + IW'(1);
                            peak_band_q <= peak_band_q + BW'(1);
                            state_q     <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    index_q     <= '0;
                    peak_band_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign index_o      = index_q;
    assign peak_valid_o = peak_valid_q;
    assign peak_band_o  = peak_band_q;
    assign peak_bin_o   = peak_bin_q;
    assign peak_mag_o   = peak_mag_q;
    assign peak_found_o = peak_found_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_fft_band_peak_picker.sv
// ---------------------------------------------------------------------------
// tb_fft_band_peak_picker
//
// Bench for fft_band_peak_picker with default parameters (BPB = 64).
// A behavioural per-band argmax model fills exp_q from the magnitude memory.
// The frame driver collects every accepted record into got_q. Each scenario
// task compares the collected records with the model and with the known
// values for that scenario.
// ---------------------------------------------------------------------------
module tb_fft_band_peak_picker;

    localparam int FFT_LENGTH = 1024;
    localparam int MW         = 16;
    localparam int NUM_BANDS  = 8;
    localparam int SKIP_DC    = 1;
    localparam int IW         = $clog2(FFT_LENGTH);
    localparam int BW         = $clog2(NUM_BANDS);
    localparam int HALF       = FFT_LENGTH / 2;
    localparam int BPB        = HALF / NUM_BANDS;
    localparam int RW         = BW + IW + MW + 1;
    localparam int BUDGET     = 20000;

    logic          clk;
    logic          reset;
    logic          start_i;
    logic [MW-1:0] threshold_i;
    logic [IW-1:0] index_o;
    logic [MW-1:0] magnitude_i;
    logic          magnitude_ready_i;
    logic          peak_valid_o;
    logic          peak_ready_i;
    logic [BW-1:0] peak_band_o;
    logic [IW-1:0] peak_bin_o;
    logic [MW-1:0] peak_mag_o;
    logic          peak_found_o;
    logic          busy_o;
    logic          frame_done_o;

    fft_band_peak_picker #(
        .FFT_LENGTH(FFT_LENGTH),
        .MAG_WIDTH (MW),
        .NUM_BANDS (NUM_BANDS),
        .SKIP_DC   (SKIP_DC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start_i),
        .threshold_i      (threshold_i),
        .index_o          (index_o),
        .magnitude_i      (magnitude_i),
        .magnitude_ready_i(magnitude_ready_i),
        .peak_valid_o     (peak_valid_o),
        .peak_ready_i     (peak_ready_i),
        .peak_band_o      (peak_band_o),
        .peak_bin_o       (peak_bin_o),
        .peak_mag_o       (peak_mag_o),
        .peak_found_o     (peak_found_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int checks;
    int failures;

    logic [MW-1:0] mem [FFT_LENGTH];
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];

    int lat;
    bit timed_out;
    bit aborted;
    int busy_viol;
    int hold_viol;
    int addr_viol;

    // Record layout: {band, bin, mag, found}
    function automatic logic [RW-1:0] pack_rec(input int band, input int bin,
                                               input int mag, input bit found);
        logic [BW-1:0] b;
        logic [IW-1:0] n;
        logic [MW-1:0] m;
        b = BW'(band);
        n = IW'(bin);
        m = MW'(mag);
        return {b, n, m, found};
    endfunction

    // Reference model: per band, the largest magnitude and the lowest bin
    // holding it. A band of zeros reports its first bin. DC never wins.
    function automatic void build_expected(input logic [MW-1:0] thr);
        int best;
        int best_bin;
        exp_q.delete();
        for (int b = 0; b < NUM_BANDS; b++) begin
            best = 0;
            best_bin = b * BPB;
            for (int i = b * BPB; i < (b + 1) * BPB; i++) begin
                if (!(SKIP_DC != 0 && i == 0) && int'(mem[i]) > best) begin
                    best = int'(mem[i]);
                    best_bin = i;
                end
            end
            exp_q.push_back(pack_rec(b, best_bin, best, best > int'(thr)));
        end
    endfunction

    // ---------------- frame driver ----------------
    task automatic run_frame(input logic [MW-1:0] thr, input int period,
                             input int stall_len, input int busy_start,
                             input bit rand_ready, input bit chg_thr,
                             input int abort_idx);
        int n;
        int stall_cnt;
        bit done;
        bit have_snap;
        logic [RW-1:0] rec;
        logic [RW-1:0] snap;
        got_q.delete();
        lat = -1;
        timed_out = 0;
        aborted = 0;
        busy_viol = 0;
        hold_viol = 0;
        addr_viol = 0;
        stall_cnt = 0;
        done = 0;
        have_snap = 0;
        snap = '0;
        @(posedge clk);
        #1;
        threshold_i = thr;
        start_i = 1'b1;
        magnitude_ready_i = 1'b0;
        peak_ready_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n = 0;
        while (!done && n < BUDGET) begin
            if (abort_idx >= 0 && int'(index_o) == abort_idx) begin
                #2 reset = 1'b1;
                #1;
                aborted = 1;
                return;
            end
            start_i = (n == busy_start);
            if (chg_thr) threshold_i = MW'($urandom);
            magnitude_ready_i = ((n % period) == 0);
            if (int'(index_o) >= HALF) addr_viol++;
            if (peak_valid_o || !magnitude_ready_i || int'(index_o) >= HALF)
                magnitude_i = MW'($urandom);
            else
                magnitude_i = mem[index_o];
            if (stall_len > 0 && peak_valid_o && peak_band_o == '0 && stall_cnt < stall_len) begin
                peak_ready_i = 1'b0;
                stall_cnt++;
            end else if (rand_ready) begin
                peak_ready_i = ($urandom_range(0, 1) == 1);
            end else begin
                peak_ready_i = 1'b1;
            end
            @(negedge clk);
            if (peak_valid_o) begin
                rec = {peak_band_o, peak_bin_o, peak_mag_o, peak_found_o};
                if (have_snap && rec !== snap) hold_viol++;
                if (int'(index_o) != int'(peak_band_o) * BPB + BPB - 1) hold_viol++;
                if (peak_ready_i) begin
                    got_q.push_back(rec);
                    have_snap = 0;
                end else begin
                    snap = rec;
                    have_snap = 1;
                end
            end
            @(posedge clk);
            n++;
            #1;
            if (frame_done_o) begin
                done = 1;
                lat = n;
            end
            if (!busy_o) busy_viol++;
        end
        start_i = 1'b0;
        magnitude_ready_i = 1'b0;
        peak_ready_i = 1'b0;
        if (!done) timed_out = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        start_i = 1'b0;
        threshold_i = '0;
        magnitude_i = '0;
        magnitude_ready_i = 1'b0;
        peak_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({index_o, peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o,
             peak_found_o, busy_o, frame_done_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got idx=%0d v=%b band=%0d bin=%0d mag=%0d f=%b busy=%b done=%b req all 0",
                     index_o, peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o,
                     peak_found_o, busy_o, frame_done_o);
        end
        reset = 1'b0;
        magnitude_ready_i = 1'b1;
        peak_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || index_o !== '0 || peak_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_without_start got busy=%b idx=%0d v=%b req 0 0 0",
                     busy_o, index_o, peak_valid_o);
        end
        magnitude_ready_i = 1'b0;
    endtask

    task automatic test_ramp();
        logic [RW-1:0] r;
        for (int i = 0; i < FFT_LENGTH; i++) mem[i] = MW'(i);
        build_expected('0);
        run_frame('0, 1, 0, -1, 0, 0, -1);
        checks++;
        if (timed_out || got_q.size() != NUM_BANDS) begin
            failures++;
            $display("FAIL ramp_count got=%0d req=%0d timeout=%0d", got_q.size(), NUM_BANDS, timed_out);
        end
        for (int i = 0; i < got_q.size() && i < NUM_BANDS; i++) begin
            r = got_q[i];
            checks++;
            if (r !== pack_rec(i, 64 * i + 63, 64 * i + 63, 1'b1)) begin
                failures++;
                $display("FAIL ramp_rec%0d got=%h req=%h", i, r, pack_rec(i, 64 * i + 63, 64 * i + 63, 1'b1));
            end
        end
        checks++;
        if (lat != HALF + NUM_BANDS) begin
            failures++;
            $display("FAIL ramp_latency got=%0d req=%0d", lat, HALF + NUM_BANDS);
        end
        checks++;
        if (busy_viol != 0 || addr_viol != 0 || hold_viol != 0) begin
            failures++;
            $display("FAIL ramp_protocol got busy=%0d addr=%0d hold=%0d req 0 0 0", busy_viol, addr_viol, hold_viol);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done_o !== 1'b0 || busy_o !== 1'b0 || index_o !== '0 || peak_band_o !== '0) begin
            failures++;
            $display("FAIL ramp_return_idle got done=%b busy=%b idx=%0d band=%0d req 0 0 0 0",
                     frame_done_o, busy_o, index_o, peak_band_o);
        end
    endtask

    task automatic load_spike();
        for (int i = 0; i < FFT_LENGTH; i++) mem[i] = MW'(5);
        mem[130] = MW'(900);
        mem[200] = MW'(300);
        mem[210] = MW'(300);
    endtask

    task automatic test_spike_ties();
        logic [RW-1:0] r;
        load_spike();
        build_expected('0);
        run_frame('0, 1, 0, -1, 0, 0, -1);
        checks++;
        if (timed_out || got_q.size() != NUM_BANDS) begin
            failures++;
            $display("FAIL spike_count got=%0d req=%0d timeout=%0d", got_q.size(), NUM_BANDS, timed_out);
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL spike_rec%0d got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
            r = got_q[2];
            checks++;
            if (r[MW+IW:MW+1] !== IW'(130) || r[MW:1] !== MW'(900)) begin
                failures++;
                $display("FAIL spike_band2 got bin=%0d mag=%0d req 130/900", r[MW+IW:MW+1], r[MW:1]);
            end
            r = got_q[3];
            checks++;
            if (r[MW+IW:MW+1] !== IW'(200) || r[MW:1] !== MW'(300)) begin
                failures++;
                $display("FAIL tie_band3 got bin=%0d mag=%0d req 200/300", r[MW+IW:MW+1], r[MW:1]);
            end
            r = got_q[0];
            checks++;
            if (r[MW+IW:MW+1] !== IW'(1) || r[MW:1] !== MW'(5)) begin
                failures++;
                $display("FAIL skip_dc_band0 got bin=%0d mag=%0d req 1/5", r[MW+IW:MW+1], r[MW:1]);
            end
        end
    endtask

    task automatic test_threshold();
        logic [RW-1:0] r;
        load_spike();
        build_expected(MW'(300));
        run_frame(MW'(300), 1, 0, -1, 0, 1, -1);
        checks++;
        if (timed_out || got_q.size() != NUM_BANDS) begin
            failures++;
            $display("FAIL thr_count got=%0d req=%0d timeout=%0d", got_q.size(), NUM_BANDS, timed_out);
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL thr_rec%0d got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
            r = got_q[3];
            checks++;
            if (r[0] !== 1'b0) begin
                failures++;
                $display("FAIL thr_equal_band3 got found=%b req 0", r[0]);
            end
            r = got_q[2];
            checks++;
            if (r[0] !== 1'b1) begin
                failures++;
                $display("FAIL thr_above_band2 got found=%b req 1", r[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < FFT_LENGTH; i++) mem[i] = MW'(i);
        build_expected('0);
        run_frame('0, 1, 10, -1, 0, 0, -1);
        checks++;
        if (timed_out || got_q.size() != NUM_BANDS) begin
            failures++;
            $display("FAIL bp_count got=%0d req=%0d timeout=%0d", got_q.size(), NUM_BANDS, timed_out);
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL bp_rec%0d got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (hold_viol != 0) begin
            failures++;
            $display("FAIL bp_hold got violations=%0d req 0", hold_viol);
        end
        checks++;
        if (lat != HALF + NUM_BANDS + 10) begin
            failures++;
            $display("FAIL bp_latency got=%0d req=%0d", lat, HALF + NUM_BANDS + 10);
        end
    endtask

    task automatic test_sparse_busy_start();
        for (int i = 0; i < FFT_LENGTH; i++) mem[i] = MW'(i);
        build_expected('0);
        run_frame('0, 3, 0, 50, 0, 0, -1);
        checks++;
        if (timed_out || got_q.size() != NUM_BANDS) begin
            failures++;
            $display("FAIL sparse_count got=%0d req=%0d timeout=%0d", got_q.size(), NUM_BANDS, timed_out);
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL sparse_rec%0d got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (busy_viol != 0 || hold_viol != 0) begin
            failures++;
            $display("FAIL sparse_busy got busy_drops=%0d hold=%0d req 0 0", busy_viol, hold_viol);
        end
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < FFT_LENGTH; i++) mem[i] = MW'(i);
        build_expected('0);
        run_frame('0, 1, 0, -1, 0, 0, 100);
        checks++;
        if (!aborted) begin
            failures++;
            $display("FAIL midreset_reach got reached=%0d req 1", aborted);
        end
        checks++;
        if ({index_o, peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o,
             peak_found_o, busy_o, frame_done_o} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got idx=%0d v=%b band=%0d bin=%0d mag=%0d f=%b busy=%b done=%b req all 0",
                     index_o, peak_valid_o, peak_band_o, peak_bin_o, peak_mag_o,
                     peak_found_o, busy_o, frame_done_o);
        end
        start_i = 1'b0;
        magnitude_ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_frame('0, 1, 0, -1, 0, 0, -1);
        checks++;
        if (timed_out || got_q.size() != NUM_BANDS) begin
            failures++;
            $display("FAIL midreset_count got=%0d req=%0d timeout=%0d", got_q.size(), NUM_BANDS, timed_out);
        end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL midreset_rec%0d got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [MW-1:0] thr;
        int period;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < FFT_LENGTH; i++) mem[i] = MW'($urandom_range(0, 15));
            thr = MW'($urandom_range(0, 15));
            period = $urandom_range(1, 3);
            build_expected(thr);
            run_frame(thr, period, 0, -1, 1, 1, -1);
            checks++;
            if (timed_out || got_q.size() != NUM_BANDS) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d req=%0d timeout=%0d", it, got_q.size(), NUM_BANDS, timed_out);
            end else begin
                for (int i = 0; i < NUM_BANDS; i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand%0d_rec%0d got=%h req=%h", it, i, got_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (hold_viol != 0 || busy_viol != 0 || addr_viol != 0) begin
                failures++;
                $display("FAIL rand%0d_protocol got hold=%0d busy=%0d addr=%0d req 0 0 0",
                         it, hold_viol, busy_viol, addr_viol);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_ramp();
        test_spike_ties();
        test_threshold();
        test_backpressure();
        test_sparse_busy_start();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
